mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 2, maximum consecutive data grants allowed while a fetch request waits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 if_req  input  1  instruction fetch request; held high with if_addr stable until granted.
REQ-005 if_addr  input  32  fetch byte address (the core's PC).
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  if_rdata valid this cycle.
REQ-008 if_rdata  output  32  fetched instruction word.
REQ-009 d_req  input  1  data request; held high with d_we/d_be/d_addr/d_wdata stable until granted.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_be  input  4  byte enables for stores.
REQ-012 d_addr  input  32  data byte address (the core's ALU_result).
REQ-013 d_wdata  input  32  store data.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  d_rdata valid this cycle (loads only).
REQ-016 d_rdata  output  32  load data.
REQ-017 mem_en  output  1  memory access issued this cycle.
REQ-018 mem_we  output  1  write strobe.
REQ-019 mem_be  output  4  byte enables.
REQ-020 mem_addr  output  32  memory byte address.
REQ-021 mem_wdata  output  32  memory write data.
REQ-022 mem_rdata  input  32  memory read data, valid exactly one cycle after a read issue.

Function
REQ-023 The block SHALL share a single synchronous memory port between fetch and data requesters, issuing at most one access per cycle.
REQ-024 Grant is combinational: the access is issued to memory (mem_en=1) in the same cycle that its gnt is high; at most one of if_gnt/d_gnt SHALL be high per cycle.
REQ-025 Arbitration: d_req wins over if_req, except when if_req is pending and the data-streak counter equals STARVE_LIMIT, in which case fetch wins.
REQ-026 Streak counter: increments (saturating at STARVE_LIMIT) on each d_gnt while if_req is high; clears on if_gnt, and clears on any cycle when if_req is low.
REQ-027 Fetch issue: mem_we=0, mem_be=4'hF, mem_addr=if_addr, mem_wdata=0.
REQ-028 Data issue: mem_we=d_we, mem_be=d_be, mem_addr=d_addr, mem_wdata=d_wdata.
REQ-029 Idle (no grant): mem_en=0, mem_we=0, mem_be=0; address/wdata don't-care.
REQ-030 Return-owner FSM, states IDLE, RD_IF, RD_D: next state = RD_IF on fetch issue, RD_D on data read issue, IDLE otherwise (including data writes).
REQ-031 In RD_IF, if_rvalid=1 and if_rdata=mem_rdata; in RD_D, d_rvalid=1 and d_rdata=mem_rdata; rdata outputs SHALL be 0 when the matching rvalid is low.
REQ-032 Read latency SHALL be exactly 1 cycle from gnt to rvalid; stores produce no rvalid.
REQ-033 Back-to-back: a new grant SHALL be allowed in the same cycle as a pending return (full throughput, one access per cycle).
REQ-034 Addresses pass unmodified; misaligned addresses are not checked or trapped.
REQ-035 A request deasserted before grant is dropped with no side effect.

Reset
REQ-036 While reset is high: FSM=IDLE, streak=0, if_gnt=d_gnt=0, mem_en=mem_we=0, mem_be=0, both rvalid=0, both rdata=0.
REQ-037 Reset asserted with a read outstanding SHALL discard the return; no rvalid in the cycle after reset.
REQ-038 First grant possible in the first cycle reset is low.

Verification
REQ-039 Fetch only: if_req=1, if_addr=0x0000_0010, mem returns 0x0051_0113 -> if_gnt=1, mem_addr=0x10, mem_be=F in cycle N; if_rvalid=1, if_rdata=0x0051_0113 in N+1.
REQ-040 Simultaneous: if_req=d_req=1, d_we=0, d_addr=0x100 every cycle, STARVE_LIMIT=2 -> grant sequence D,D,IF,D,D,IF; rvalid owners follow one cycle later.
REQ-041 Store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x204, d_wdata=0xDEAD_BEEF -> mem_we=1, mem_be=3, mem_wdata=0xDEADBEEF; no d_rvalid next cycle.
REQ-042 Back-to-back loads 0x100, 0x104 on consecutive cycles -> d_gnt on both cycles, d_rvalid high for two consecutive cycles with matching data.
REQ-043 Reset mid-read: fetch granted in cycle N, reset=1 in cycle N+1 -> if_rvalid=0 in N+1 and N+2; all outputs at reset values.
REQ-044 if_req idle: d_req held high 5 cycles with if_req=0 -> d_gnt every cycle, streak stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between fetch and data, data-first with fetch starvation guard
module mem_arbiter #(
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, RD_IF, RD_D} state_t;
    state_t state, state_nx;
    logic [SW-1:0] streak;
    logic fetch_win;
    always_comb begin
        fetch_win = if_req && (!d_req || streak == SW'(STARVE_LIMIT));
        if_gnt    = !reset && fetch_win;
        d_gnt     = !reset && d_req && !fetch_win;
        mem_en    = if_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_be    = if_gnt ? 4'hF : (d_gnt ? d_be : 4'h0);
        mem_addr  = if_gnt ? if_addr : d_addr;
        mem_wdata = d_gnt ? d_wdata : 32'h0;
        state_nx  = if_gnt ? RD_IF : ((d_gnt && !d_we) ? RD_D : IDLE);
        if_rvalid = !reset && state == RD_IF;
        d_rvalid  = !reset && state == RD_D;
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        d_rdata   = d_rvalid ? mem_rdata : 32'h0;
    end
    // streak only counts data grants that actually made a waiting fetch wait
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state <= state_nx;
            if (!if_req || if_gnt)
                streak <= '0;
            else if (d_gnt && streak != SW'(STARVE_LIMIT))
                streak <= streak + SW'(1);
        end
    end
endmodule
